// File: rtl/pong_match_ctrl_if.sv
// Match-controller signal bundle: stimulus from the game top (frame tick,
// start button, goal pulses) and the ball/score controls driven back.
interface pong_match_ctrl_if;
    logic       frameTick;
    logic       startBtn;
    logic       goalLeft;
    logic       goalRight;
    logic       ballRun;
    logic       ballRecentre;
    logic       serveDir;
    logic [3:0] score1;
    logic [3:0] score2;
    logic       gameOver;
    logic       winner;
    logic [2:0] state;

    // Game top / bench side
    modport master (
        output frameTick, startBtn, goalLeft, goalRight,
        input  ballRun, ballRecentre, serveDir, score1, score2,
               gameOver, winner, state
    );

    // Match controller side
    modport slave (
        input  frameTick, startBtn, goalLeft, goalRight,
        output ballRun, ballRecentre, serveDir, score1, score2,
               gameOver, winner, state
    );
endinterface

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: holds, recentres, serves and releases the ball,
// counts goals into two 4-bit scores and detects the end of the match.
// All outputs are registered; reset is synchronous and active-high.
module pong_match_ctrl #(
    parameter int unsigned SERVE_FRAMES   = 60,
    parameter int unsigned POINT_FRAMES   = 30,
    parameter int unsigned WIN_SCORE      = 9,
    parameter logic        SERVE_DIR_INIT = 1'b1
) (
    input  logic              PixelClock,
    input  logic              Reset,
    pong_match_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SERVE    = 3'd1,
        PLAY     = 3'd2,
        POINT    = 3'd3,
        GAMEOVER = 3'd4
    } state_t;

    localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0] POINT_LAST = 8'(POINT_FRAMES - 1);
    localparam logic [3:0] WIN        = 4'(WIN_SCORE);

    state_t     state_q, state_d;
    logic [7:0] frames_q, frames_d;
    logic [3:0] score1_q, score1_d;
    logic [3:0] score2_q, score2_d;
    logic       serveDir_q, serveDir_d;
    logic       winner_q, winner_d;
    logic       recentre_q, recentre_d;
    logic       ballRun_q;
    logic       gameOver_q;
    logic       startBtn_q;
    logic       startRise;

    // Reset value of 1 means a button held through reset never starts a match.
    assign startRise = bus.startBtn & ~startBtn_q;

    // Next-state, score, direction and recentre decisions
    always_comb begin
        state_d    = state_q;
        score1_d   = score1_q;
        score2_d   = score2_q;
        serveDir_d = serveDir_q;
        winner_d   = winner_q;
        recentre_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (startRise) begin
                    state_d    = SERVE;
                    score1_d   = '0;
                    score2_d   = '0;
                    recentre_d = 1'b1;
                end
            end
            SERVE: begin
                if (bus.frameTick && (frames_q == SERVE_LAST))
                    state_d = PLAY;
            end
            PLAY: begin
                if (bus.goalLeft || bus.goalRight) begin
                    state_d = POINT;
                    if (bus.goalLeft && !bus.goalRight) begin
                        if (score1_q < WIN)
                            score1_d = score1_q + 4'd1;
                        serveDir_d = 1'b1;
                    end else if (bus.goalRight && !bus.goalLeft) begin
                        if (score2_q < WIN)
                            score2_d = score2_q + 4'd1;
                        serveDir_d = 1'b0;
                    end
                end
            end
            POINT: begin
                if ((score1_q == WIN) || (score2_q == WIN)) begin
                    state_d  = GAMEOVER;
                    winner_d = (score2_q == WIN);
                end else if (bus.frameTick && (frames_q == POINT_LAST)) begin
                    state_d    = SERVE;
                    recentre_d = 1'b1;
                end
            end
            GAMEOVER: begin
                if (startRise) begin
                    state_d    = SERVE;
                    score1_d   = '0;
                    score2_d   = '0;
                    recentre_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A tick coinciding with a transition belongs to neither state.
        if (state_d != state_q)
            frames_d = '0;
        else
            frames_d = frames_q + {7'd0, bus.frameTick};
    end

    // State, counters and registered outputs
    always_ff @(posedge PixelClock) begin
        if (Reset) begin
            state_q    <= IDLE;
            frames_q   <= '0;
            score1_q   <= '0;
            score2_q   <= '0;
            serveDir_q <= SERVE_DIR_INIT;
            winner_q   <= 1'b0;
            recentre_q <= 1'b0;
            ballRun_q  <= 1'b0;
            gameOver_q <= 1'b0;
            startBtn_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            frames_q   <= frames_d;
            score1_q   <= score1_d;
            score2_q   <= score2_d;
            serveDir_q <= serveDir_d;
            winner_q   <= winner_d;
            recentre_q <= recentre_d;
            ballRun_q  <= (state_d == PLAY);
            gameOver_q <= (state_d == GAMEOVER);
            startBtn_q <= bus.startBtn;
        end
    end

    assign bus.state        = state_q;
    assign bus.ballRun      = ballRun_q;
    assign bus.ballRecentre = recentre_q;
    assign bus.serveDir     = serveDir_q;
    assign bus.score1       = score1_q;
    assign bus.score2       = score2_q;
    assign bus.gameOver     = gameOver_q;
    assign bus.winner       = winner_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Bench for pong_match_ctrl: directed match scenarios followed by random
// stimulus, checked cycle by cycle against a match-rules reference model
// through an expectation queue.
module tb_pong_match_ctrl;

    localparam int SF  = 60;
    localparam int PF  = 30;
    localparam int WIN = 3;
    localparam bit DIR0 = 1'b1;

    typedef struct {
        logic [2:0] st;
        logic       run;
        logic       rec;
        logic       dir;
        logic [3:0] s1;
        logic [3:0] s2;
        logic       go;
        logic       win;
    } exp_t;

    logic PixelClock = 1'b0;
    logic Reset      = 1'b1;
    pong_match_ctrl_if bus ();

    pong_match_ctrl #(
        .SERVE_FRAMES   (SF),
        .POINT_FRAMES   (PF),
        .WIN_SCORE      (WIN),
        .SERVE_DIR_INIT (DIR0)
    ) dut (
        .PixelClock (PixelClock),
        .Reset      (Reset),
        .bus        (bus)
    );

    always #5 PixelClock = ~PixelClock;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    bit   done   = 0;
    bit   btn    = 0;

    // Reference model: match phase named by its displayed number, frames
    // elapsed in that phase, scores, last scorer's serve side, button memory.
    int phase = 0, frames = 0, sc1 = 0, sc2 = 0;
    bit dir = DIR0, btn_prev = 1, rec = 0, win = 0;

    task automatic model(input bit rst, tick, b, gl, gr);
        int  nxt;
        bit  press;
        exp_t e;
        if (rst) begin
            phase = 0; frames = 0; sc1 = 0; sc2 = 0;
            dir = DIR0; btn_prev = 1; rec = 0; win = 0;
        end else begin
            press    = b && !btn_prev;
            btn_prev = b;
            nxt      = phase;
            rec      = 0;
            if (phase == 0 || phase == 4) begin
                if (press) begin nxt = 1; sc1 = 0; sc2 = 0; rec = 1; end
            end else if (phase == 1) begin
                if (tick && frames + 1 == SF) nxt = 2;
            end else if (phase == 2) begin
                if (gl || gr) nxt = 3;
                if (gl && !gr) begin if (sc1 < WIN) sc1++; dir = 1; end
                if (gr && !gl) begin if (sc2 < WIN) sc2++; dir = 0; end
            end else if (phase == 3) begin
                if (sc1 == WIN || sc2 == WIN) begin nxt = 4; win = (sc2 == WIN); end
                else if (tick && frames + 1 == PF) begin nxt = 1; rec = 1; end
            end
            frames = (nxt != phase) ? 0 : frames + int'(tick);
            phase  = nxt;
        end
        e.st  = 3'(phase);
        e.run = (phase == 2);
        e.rec = rec;
        e.dir = dir;
        e.s1  = 4'(sc1);
        e.s2  = 4'(sc2);
        e.go  = (phase == 4);
        e.win = win;
        exp_q.push_back(e);
    endtask

    // One clock of stimulus: drive, predict, advance to just after the edge.
    task automatic cyc(input bit rst, tick, b, gl, gr);
        Reset         = rst;
        bus.frameTick = tick;
        bus.startBtn  = b;
        bus.goalLeft  = gl;
        bus.goalRight = gr;
        model(rst, tick, b, gl, gr);
        @(posedge PixelClock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(0, 1, btn, 0, 0);
            cyc(0, 0, btn, 0, 0);
        end
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    endtask

    // Monitor: every clock the DUT presents a full set of outputs; compare
    // them against the oldest outstanding prediction.
    initial begin
        exp_t e;
        while (!done) begin
            @(posedge PixelClock);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("state",        int'(bus.state),        int'(e.st));
                chk("ballRun",      int'(bus.ballRun),      int'(e.run));
                chk("ballRecentre", int'(bus.ballRecentre), int'(e.rec));
                chk("serveDir",     int'(bus.serveDir),     int'(e.dir));
                chk("score1",       int'(bus.score1),       int'(e.s1));
                chk("score2",       int'(bus.score2),       int'(e.s2));
                chk("gameOver",     int'(bus.gameOver),     int'(e.go));
                if (e.go) chk("winner", int'(bus.winner), int'(e.win));
            end
        end
    end

    // Stimulus
    initial begin
        bus.frameTick = 0; bus.startBtn = 1; bus.goalLeft = 0; bus.goalRight = 0;
        #1;
        // Button held through reset must not start a match
        btn = 1;
        repeat (3) cyc(1, 0, btn, 0, 0);
        repeat (3) cyc(0, 0, btn, 0, 0);
        btn = 0;
        cyc(0, 0, btn, 0, 1);           // goal in IDLE ignored
        btn = 1;
        cyc(0, 0, btn, 0, 0);           // start
        cyc(0, 1, btn, 1, 0);           // goal + tick on first SERVE cycle
        ticks(SF - 1);
        cyc(0, 0, btn, 0, 0);
        cyc(0, 0, btn, 1, 0);           // goalLeft in PLAY
        ticks(PF);
        ticks(SF);
        cyc(0, 0, btn, 1, 1);           // simultaneous goals
        ticks(PF);
        // Three goalRight rallies: score2 reaches WIN
        for (int r = 0; r < WIN; r++) begin
            ticks(SF);
            cyc(0, 0, btn, 0, 1);
            ticks(PF);
        end
        cyc(0, 0, btn, 0, 1);           // goals in GAMEOVER ignored
        cyc(0, 1, btn, 1, 0);
        repeat (4) cyc(0, 0, btn, 0, 0);  // held button: no restart
        btn = 0;
        cyc(0, 0, btn, 0, 0);
        btn = 1;
        cyc(0, 0, btn, 0, 0);           // restart
        ticks(20);
        cyc(1, 0, btn, 0, 0);           // reset mid-SERVE
        btn = 0;
        cyc(0, 0, btn, 0, 0);
        btn = 1;
        cyc(0, 0, btn, 0, 0);
        ticks(SF);
        cyc(0, 0, btn, 0, 0);
        cyc(1, 0, btn, 1, 0);           // reset with goal in PLAY
        cyc(0, 0, btn, 0, 0);

        // Random play
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 49) == 0) btn = ~btn;
            cyc(($urandom_range(0, 2999) == 0),
                ($urandom_range(0, 2) == 0),
                btn,
                ($urandom_range(0, 29) == 0),
                ($urandom_range(0, 29) == 0));
        end
        cyc(0, 0, btn, 0, 0);
        @(posedge PixelClock);
        #3;
        done = 1;
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL queue_drain: got %0d left expected 0", exp_q.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
